// File: rtl/mem_arbiter.sv
// Two-requester (instruction fetch, load/store) arbiter onto one memory port, one transaction in flight.
// Optional build macro MEM_ARB_RR_EN: ties alternate between requesters instead of always favouring LS.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  // instruction fetch port
  input  logic                  if_valid,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ready,
  output logic                  if_rvalid,
  output logic [31:0]           if_rdata,
  output logic                  if_err,
  // load/store port
  input  logic                  ls_valid,
  input  logic                  ls_we,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [31:0]           ls_wdata,
  input  logic [3:0]            ls_wmask,
  output logic                  ls_ready,
  output logic                  ls_rvalid,
  output logic [31:0]           ls_rdata,
  output logic                  ls_err,
  // memory port
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wmask,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic                  owner_ls_reg, owner_ls_next;
  logic                  we_reg, we_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [31:0]           wdata_reg, wdata_next;
  logic [3:0]            wmask_reg, wmask_next;
  logic                  if_rvalid_reg, if_rvalid_next;
  logic                  ls_rvalid_reg, ls_rvalid_next;
  logic [31:0]           rdata_reg, rdata_next;
  logic                  err_reg, err_next;
  logic                  grant_ls, grant_if;
  logic                  timeout_hit, respond, resp_ok;
`ifdef MEM_ARB_RR_EN
  logic                  last_ls_reg, last_ls_next;
`endif

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    owner_ls_next  = owner_ls_reg;
    we_next        = we_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    wmask_next     = wmask_reg;
    if_rvalid_next = 1'b0;
    ls_rvalid_next = 1'b0;
    rdata_next     = rdata_reg;
    err_next       = 1'b0;
    grant_ls       = 1'b0;
    grant_if       = 1'b0;
    respond        = 1'b0;
    resp_ok        = 1'b0;
    timeout_hit    = (cnt_reg == CNT_W'(TIMEOUT - 1));
`ifdef MEM_ARB_RR_EN
    last_ls_next   = last_ls_reg;
`endif

    case (state_reg)
      IDLE: begin
        // No grant while reset is held, so nothing is handshaken that reset would discard.
        if (!rst) begin
`ifdef MEM_ARB_RR_EN
          if (ls_valid && if_valid) grant_ls = !last_ls_reg;
          else                      grant_ls = ls_valid;
`else
          grant_ls = ls_valid;
`endif
          grant_if = if_valid && !grant_ls;
        end
        if (grant_ls) begin
          owner_ls_next = 1'b1;
          we_next       = ls_we;
          addr_next     = ls_addr;
          wdata_next    = ls_wdata;
          wmask_next    = ls_wmask;
          cnt_next      = '0;
          state_next    = REQ;
        end else if (grant_if) begin
          owner_ls_next = 1'b0;
          we_next       = 1'b0;
          addr_next     = if_addr;
          wdata_next    = '0;
          wmask_next    = 4'hF;
          cnt_next      = '0;
          state_next    = REQ;
        end
`ifdef MEM_ARB_RR_EN
        if (grant_ls || grant_if) last_ls_next = grant_ls;
`endif
      end
      REQ: begin
        cnt_next = cnt_reg + CNT_W'(1);
        if (timeout_hit) begin
          respond    = 1'b1;
          state_next = IDLE;
        end else if (mem_ready) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt_reg + CNT_W'(1);
        // A response arriving on the timeout cycle still counts as a good completion.
        if (mem_rvalid) begin
          respond    = 1'b1;
          resp_ok    = 1'b1;
          state_next = IDLE;
        end else if (timeout_hit) begin
          respond    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (respond) begin
      ls_rvalid_next = owner_ls_reg;
      if_rvalid_next = !owner_ls_reg;
      err_next       = !resp_ok;
      rdata_next     = (resp_ok && !we_reg) ? mem_rdata : 32'h0;
    end

    ls_ready = grant_ls;
    if_ready = grant_if;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      owner_ls_reg  <= 1'b0;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      wmask_reg     <= '0;
      if_rvalid_reg <= 1'b0;
      ls_rvalid_reg <= 1'b0;
      rdata_reg     <= '0;
      err_reg       <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_ls_reg   <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      owner_ls_reg  <= owner_ls_next;
      we_reg        <= we_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      wmask_reg     <= wmask_next;
      if_rvalid_reg <= if_rvalid_next;
      ls_rvalid_reg <= ls_rvalid_next;
      rdata_reg     <= rdata_next;
      err_reg       <= err_next;
`ifdef MEM_ARB_RR_EN
      last_ls_reg   <= last_ls_next;
`endif
    end
  end

  assign mem_req   = (state_reg == REQ);
  assign mem_we    = (state_reg == REQ) && we_reg;
  assign mem_wmask = (state_reg == REQ) ? wmask_reg : 4'h0;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;

  // Response data and error are shared and only presented to the requester being answered.
  assign if_rvalid = if_rvalid_reg;
  assign if_rdata  = if_rvalid_reg ? rdata_reg : 32'h0;
  assign if_err    = if_rvalid_reg && err_reg;
  assign ls_rvalid = ls_rvalid_reg;
  assign ls_rdata  = ls_rvalid_reg ? rdata_reg : 32'h0;
  assign ls_err    = ls_rvalid_reg && err_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle-by-cycle vector table plus timeout, tie and reset sequences.
module tb_mem_arbiter;

  localparam logic [31:0] A0 = 32'h8000_0000;
  localparam logic [31:0] A4 = 32'h8000_0004;
  localparam logic [31:0] AL = 32'h8000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_valid = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ready, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        ls_valid = 1'b0, ls_we = 1'b0;
  logic [31:0] ls_addr = '0, ls_wdata = '0;
  logic [3:0]  ls_wmask = '0;
  logic        ls_ready, ls_rvalid, ls_err;
  logic [31:0] ls_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ready = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_addr(if_addr), .if_ready(if_ready),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .ls_valid(ls_valid), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_wmask(ls_wmask), .ls_ready(ls_ready), .ls_rvalid(ls_rvalid),
    .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        rst, ifv;
    logic [31:0] ifa;
    logic        lsv, lswe;
    logic [31:0] lsa, lswd;
    logic [3:0]  lswm;
    logic        mrdy, mrv;
    logic [31:0] mrd;
    logic        chk;
    logic [1:0]  e_rdy;     // {ls_ready, if_ready}
    logic        e_req, e_we;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_wmask;
    logic [1:0]  e_rv;      // {ls_rvalid, if_rvalid}
    logic [31:0] e_rdata;
    logic        e_err;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
      input logic r, input logic ifv, input logic [31:0] ifa,
      input logic lsv, input logic lswe, input logic [31:0] lsa, input logic [31:0] lswd,
      input logic [3:0] lswm, input logic mrdy, input logic mrv, input logic [31:0] mrd,
      input logic c, input logic [1:0] er, input logic eq, input logic ewe,
      input logic [31:0] ea, input logic [31:0] ewd, input logic [3:0] ewm,
      input logic [1:0] erv, input logic [31:0] erd, input logic eerr);
    vec_t v;
    v.rst = r; v.ifv = ifv; v.ifa = ifa; v.lsv = lsv; v.lswe = lswe; v.lsa = lsa;
    v.lswd = lswd; v.lswm = lswm; v.mrdy = mrdy; v.mrv = mrv; v.mrd = mrd; v.chk = c;
    v.e_rdy = er; v.e_req = eq; v.e_we = ewe; v.e_addr = ea; v.e_wdata = ewd;
    v.e_wmask = ewm; v.e_rv = erv; v.e_rdata = erd; v.e_err = eerr;
    return v;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endfunction

  task automatic clear_inputs();
    if_valid = 0; if_addr = '0; ls_valid = 0; ls_we = 0; ls_addr = '0;
    ls_wdata = '0; ls_wmask = '0; mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  // One line per completed response.
  always @(negedge clk) begin
    #2;
    if (if_rvalid) $display("txn IF response rdata=%08h err=%0b", if_rdata, if_err);
    if (ls_rvalid) $display("txn LS response rdata=%08h err=%0b", ls_rdata, ls_err);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit exp_g[4];
    int g, last_c;

    // rst,ifv,ifa,lsv,we,lsa,wdata,wmask,mrdy,mrv,mrd | chk,rdy,req,we,addr,wdata,wmask,rv,rdata,err
    tv.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,            0,2'b00,0,0,0,0,0,2'b00,0,0));
    tv.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,            0,2'b00,0,0,0,0,0,2'b00,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,            1,2'b00,0,0,0,0,0,2'b00,0,0));
    tv.push_back(mk(0,1,A0,0,0,0,0,0,0,0,0,           1,2'b01,0,0,0,0,0,2'b00,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,1,0,0,            1,2'b00,1,0,A0,0,4'hF,2'b00,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,0,1,32'h00100073, 1,2'b00,0,0,0,0,0,2'b00,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,            1,2'b00,0,0,0,0,0,2'b01,32'h00100073,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,            1,2'b00,0,0,0,0,0,2'b00,0,0));
    tv.push_back(mk(0,0,0,1,1,AL,32'hDEADBEEF,4'h3,0,0,0, 1,2'b10,0,0,0,0,0,2'b00,0,0));
    tv.push_back(mk(0,0,0,1,0,32'hFFFFFFF0,0,4'hF,0,0,0,  1,2'b00,1,1,AL,32'hDEADBEEF,4'h3,2'b00,0,0));
    tv.push_back(mk(0,1,A4,0,0,0,0,0,0,1,32'h11111111,    1,2'b00,1,1,AL,32'hDEADBEEF,4'h3,2'b00,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,            1,2'b00,1,1,AL,32'hDEADBEEF,4'h3,2'b00,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,1,0,0,            1,2'b00,1,1,AL,32'hDEADBEEF,4'h3,2'b00,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,            1,2'b00,0,0,0,0,0,2'b00,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,0,1,32'h12345678, 1,2'b00,0,0,0,0,0,2'b00,0,0));
    tv.push_back(mk(0,1,A4,0,0,0,0,0,0,0,0,           1,2'b01,0,0,0,0,0,2'b10,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,1,0,0,            1,2'b00,1,0,A4,0,4'hF,2'b00,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,0,1,32'hAABBCCDD, 1,2'b00,0,0,0,0,0,2'b00,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,            1,2'b00,0,0,0,0,0,2'b01,32'hAABBCCDD,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,            1,2'b00,0,0,0,0,0,2'b00,0,0));
    tv.push_back(mk(0,1,A0,1,0,AL,0,4'hF,0,0,0,       1,2'b10,0,0,0,0,0,2'b00,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,1,0,0,            1,2'b00,1,0,AL,0,4'hF,2'b00,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,0,1,32'h5A5A5A5A, 1,2'b00,0,0,0,0,0,2'b00,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,            1,2'b00,0,0,0,0,0,2'b10,32'h5A5A5A5A,0));

    foreach (tv[i]) begin
      @(negedge clk);
      rst = tv[i].rst; if_valid = tv[i].ifv; if_addr = tv[i].ifa;
      ls_valid = tv[i].lsv; ls_we = tv[i].lswe; ls_addr = tv[i].lsa;
      ls_wdata = tv[i].lswd; ls_wmask = tv[i].lswm; mem_ready = tv[i].mrdy;
      mem_rvalid = tv[i].mrv; mem_rdata = tv[i].mrd;
      #1;
      if (tv[i].chk) begin
        chk($sformatf("v%0d.ls_ready", i), ls_ready, tv[i].e_rdy[1]);
        chk($sformatf("v%0d.if_ready", i), if_ready, tv[i].e_rdy[0]);
        chk($sformatf("v%0d.mem_req", i), mem_req, tv[i].e_req);
        chk($sformatf("v%0d.mem_we", i), mem_we, tv[i].e_we);
        chk($sformatf("v%0d.mem_wmask", i), mem_wmask, tv[i].e_wmask);
        if (tv[i].e_req) chk($sformatf("v%0d.mem_addr", i), mem_addr, tv[i].e_addr);
        if (tv[i].e_req && tv[i].e_we) chk($sformatf("v%0d.mem_wdata", i), mem_wdata, tv[i].e_wdata);
        chk($sformatf("v%0d.ls_rvalid", i), ls_rvalid, tv[i].e_rv[1]);
        chk($sformatf("v%0d.if_rvalid", i), if_rvalid, tv[i].e_rv[0]);
        if (tv[i].e_rv[1]) begin
          chk($sformatf("v%0d.ls_rdata", i), ls_rdata, tv[i].e_rdata);
          chk($sformatf("v%0d.ls_err", i), ls_err, tv[i].e_err);
        end
        if (tv[i].e_rv[0]) begin
          chk($sformatf("v%0d.if_rdata", i), if_rdata, tv[i].e_rdata);
          chk($sformatf("v%0d.if_err", i), if_err, tv[i].e_err);
        end
      end
    end

    // Both requesters valid every cycle with a 0-wait memory.
`ifdef MEM_ARB_RR_EN
    exp_g = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_g = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    do_reset();
    g = 0;
    last_c = 0;
    for (int c = 0; c < 40 && g < 4; c++) begin
      @(negedge clk);
      ls_valid = 1; ls_we = 0; ls_addr = AL; ls_wmask = 4'hF;
      if_valid = 1; if_addr = A4; mem_ready = 1; mem_rvalid = 1; mem_rdata = 32'h0000_0001;
      #1;
      chk("tie.exclusive_ready", ls_ready && if_ready, 0);
      if (ls_ready || if_ready) begin
        chk($sformatf("tie.grant%0d_is_ls", g), ls_ready, exp_g[g]);
        if (g > 0) begin
          chk($sformatf("tie.spacing%0d", g), c - last_c, 3);
          chk($sformatf("tie.resp%0d_ls", g), ls_rvalid, exp_g[g-1]);
          chk($sformatf("tie.resp%0d_if", g), if_rvalid, !exp_g[g-1]);
        end
        last_c = c;
        g++;
      end
    end
    chk("tie.grant_count", g, 4);

    // Timeout in WAIT, then a late memory response that must be ignored.
    do_reset();
    @(negedge clk); ls_valid = 1; ls_we = 0; ls_addr = AL; ls_wmask = 4'hF; #1;
    chk("to1.grant", ls_ready, 1);
    @(negedge clk); ls_valid = 0; mem_ready = 1; #1;
    chk("to1.req", mem_req, 1);
    for (int k = 1; k < 8; k++) begin
      @(negedge clk); mem_ready = 0; #1;
      chk($sformatf("to1.k%0d_rvalid", k), ls_rvalid, 0);
      chk($sformatf("to1.k%0d_mem_req", k), mem_req, 0);
    end
    @(negedge clk); #1;
    chk("to1.rvalid", ls_rvalid, 1);
    chk("to1.err", ls_err, 1);
    chk("to1.rdata", ls_rdata, 0);
    chk("to1.mem_req", mem_req, 0);
    @(negedge clk); mem_rvalid = 1; mem_rdata = 32'hDEAD0001; #1;
    chk("to1.pulse_end", ls_rvalid, 0);
    @(negedge clk); mem_rvalid = 0; #1;
    chk("to1.late_ls", ls_rvalid, 0);
    chk("to1.late_if", if_rvalid, 0);

    // Timeout while memory never accepts the request.
    do_reset();
    @(negedge clk); if_valid = 1; if_addr = A0; #1;
    chk("to2.grant", if_ready, 1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); if_valid = 0; #1;
      chk($sformatf("to2.k%0d_mem_req", k), mem_req, 1);
      chk($sformatf("to2.k%0d_rvalid", k), if_rvalid, 0);
    end
    @(negedge clk); #1;
    chk("to2.mem_req", mem_req, 0);
    chk("to2.rvalid", if_rvalid, 1);
    chk("to2.err", if_err, 1);
    chk("to2.rdata", if_rdata, 0);

    // Response on the very cycle the timeout would fire wins.
    do_reset();
    @(negedge clk); ls_valid = 1; ls_we = 0; ls_addr = AL; ls_wmask = 4'hF; #1;
    chk("to3.grant", ls_ready, 1);
    @(negedge clk); ls_valid = 0; mem_ready = 1; #1;
    chk("to3.req", mem_req, 1);
    for (int k = 1; k < 8; k++) begin
      @(negedge clk); mem_ready = 0;
      mem_rvalid = (k == 7); mem_rdata = 32'hCAFEF00D; #1;
      chk($sformatf("to3.k%0d_rvalid", k), ls_rvalid, 0);
    end
    @(negedge clk); mem_rvalid = 0; #1;
    chk("to3.rvalid", ls_rvalid, 1);
    chk("to3.err", ls_err, 0);
    chk("to3.rdata", ls_rdata, 32'hCAFEF00D);

    // Reset while waiting for memory drops the transaction.
    do_reset();
    @(negedge clk); ls_valid = 1; ls_we = 0; ls_addr = AL; ls_wmask = 4'hF; #1;
    chk("rw.grant", ls_ready, 1);
    @(negedge clk); ls_valid = 0; mem_ready = 1; #1;
    chk("rw.req", mem_req, 1);
    @(negedge clk); mem_ready = 0; rst = 1; #1;
    chk("rw.wait_no_req", mem_req, 0);
    @(negedge clk); rst = 0; mem_rvalid = 1; mem_rdata = 32'hBAD00BAD; #1;
    chk("rw.zero_mem_req", mem_req, 0);
    chk("rw.zero_mem_we", mem_we, 0);
    chk("rw.zero_mem_addr", mem_addr, 0);
    chk("rw.zero_mem_wdata", mem_wdata, 0);
    chk("rw.zero_mem_wmask", mem_wmask, 0);
    chk("rw.zero_ready", {ls_ready, if_ready}, 0);
    chk("rw.zero_rvalid", {ls_rvalid, if_rvalid}, 0);
    chk("rw.zero_rdata", ls_rdata | if_rdata, 0);
    chk("rw.zero_err", {ls_err, if_err}, 0);
    @(negedge clk); mem_rvalid = 0; #1;
    chk("rw.stale_rvalid1", {ls_rvalid, if_rvalid}, 0);
    @(negedge clk); #1;
    chk("rw.stale_rvalid2", {ls_rvalid, if_rvalid}, 0);
    @(negedge clk); if_valid = 1; if_addr = A4; #1;
    chk("rw.if_grant", if_ready, 1);
    @(negedge clk); if_valid = 0; mem_ready = 1; #1;
    chk("rw.if_req", mem_req, 1);
    chk("rw.if_addr", mem_addr, A4);
    @(negedge clk); mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h0000_0013; #1;
    chk("rw.if_wait", mem_req, 0);
    @(negedge clk); mem_rvalid = 0; #1;
    chk("rw.if_rvalid", if_rvalid, 1);
    chk("rw.if_rdata", if_rdata, 32'h0000_0013);
    chk("rw.if_err", if_err, 0);
    chk("rw.ls_quiet", ls_rvalid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
